// File: rtl/raybox_pkg.sv
// Shared definitions for the raycaster arithmetic blocks.
//   MODE_LZ   : count leading zeros of an unsigned operand
//   MODE_SIGN : count redundant sign bits of a two's complement operand
//   calc_cw   : width of a count able to hold 0..width
package raybox_pkg;

  localparam logic MODE_LZ   = 1'b0;
  localparam logic MODE_SIGN = 1'b1;

  function automatic int calc_cw(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/lzc_core.sv
// Combinational leading-zero / redundant-sign-bit counter.
// Ports:
//   data  [WIDTH-1:0] operand
//   mode              MODE_LZ or MODE_SIGN
//   count [CW-1:0]    shift that normalises data
//   zero              data is all zeros
module lzc_core
  import raybox_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CW = calc_cw(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  output logic [CW-1:0]    count,
  output logic             zero
);

  // A bit differs from the sign exactly where sign_vec is 1, so the leading
  // zeros of sign_vec are the redundant sign bits.
  logic [WIDTH-2:0] sign_vec;
  logic [CW-1:0]    lz_count;
  logic [CW-1:0]    sign_count;

  assign sign_vec = data[WIDTH-2:0] ^ {(WIDTH-1){data[WIDTH-1]}};

  // Scanning upward with last-write-wins leaves the highest set bit in effect.
  always_comb begin
    lz_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) lz_count = CW'(WIDTH - 1 - i);
    end
  end

  always_comb begin
    sign_count = CW'(WIDTH - 1);
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (sign_vec[i]) sign_count = CW'(WIDTH - 2 - i);
    end
  end

  assign count = (mode == MODE_SIGN) ? sign_count : lz_count;
  assign zero  = ~|data;

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage pipelined leading-zero / sign-bit counter with normalising shift.
// S1 registers the operand together with its count; S2 registers the shifted
// result and drives the output port.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   in_valid/in_ready               input handshake
//   in_data, in_mode, in_tag        operand, count mode, sideband tag
//   out_valid/out_ready             output handshake
//   out_count, out_norm, out_zero   shift count, normalised data, zero flag
//   out_tag                         tag of the result
module lzc_norm_pipe
  import raybox_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  localparam int CW = calc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [TAG_W-1:0] s1_tag;
  logic [CW-1:0]    s1_count;
  logic             s1_zero;

  logic [CW-1:0]    core_count;
  logic             core_zero;
  logic             s2_load;
  logic             in_fire;
  logic [WIDTH-1:0] norm_next;

  lzc_core #(.WIDTH(WIDTH)) u_core (
    .data  (in_data),
    .mode  (in_mode),
    .count (core_count),
    .zero  (core_zero)
  );

  // Derived from stage state and out_ready only, never from in_valid.
  assign s2_load  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_load;
  assign in_fire  = in_valid & in_ready;

  // A shift amount of WIDTH or more yields zero, covering all-zero mode 0.
  assign norm_next = s1_data << s1_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Payload registers are qualified by s1_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_data  <= in_data;
      s1_tag   <= in_tag;
      s1_count <= core_count;
      s1_zero  <= core_zero;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_norm  <= '0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_count <= s1_count;
        out_norm  <= norm_next;
        out_zero  <= s1_zero;
        out_tag   <= s1_tag;
      end
    end
  end

endmodule
